// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for the serial frame transmitter.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int MAX_DATA_W = 32;

    // Counter width that stays at least one bit even for n <= 2.
    function automatic int width_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    // Zero padding above the real word does not change the XOR reduction.
    function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the wrap cycle.
module serial_frame_tx_bit_timer
    import serial_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int TW = width_min1(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= tick_o ? '0 : cnt_q + TW'(1);
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// UART-style frame transmitter: start, DATA_W bits LSB-first, optional parity, stop.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_dout,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int BW = width_min1(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    tx_state_t         state_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [BW-1:0]     bit_q;
    logic              par_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              dout_q;
    logic              accept;
    logic              tick;

    assign accept  = tx_valid && ready_q;
    assign shift_d = shift_q >> 1;

    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;
    assign tx_dout  = dout_q;

    serial_frame_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .en_i   (busy_q),
        .clr_i  (accept),
        .tick_o (tick)
    );

    // Line value is registered one state ahead so each bit appears on the
    // cycle right after the edge that enters its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= START;
                        shift_q <= tx_data;
                        par_q   <= calc_parity(MAX_DATA_W'(tx_data), PARITY_ODD != 0);
                        bit_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        dout_q  <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        state_q <= DATA;
                        dout_q  <= shift_q[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_q == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                state_q <= PARITY;
                                dout_q  <= par_q;
                            end else begin
                                state_q <= STOP;
                                dout_q  <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + BW'(1);
                            shift_q <= shift_d;
                            dout_q  <= shift_d[0];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state_q <= STOP;
                        dout_q  <= 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        dout_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    dout_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench: three transmitter configurations checked against a per-bit frame model.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data  [3];
    logic       valid [3];
    logic       dout  [3];
    logic       ready [3];
    logic       busy  [3];
    logic       done  [3];

    int cpb_of [3] = '{4, 4, 1};
    int pe_of  [3] = '{1, 1, 0};
    int odd_of [3] = '{0, 1, 0};

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_def (
        .clk(clk), .rst(rst), .tx_data(data[0]), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .tx_dout(dout[0]), .tx_busy(busy[0]), .tx_done(done[0]));

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk(clk), .rst(rst), .tx_data(data[1]), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .tx_dout(dout[1]), .tx_busy(busy[1]), .tx_done(done[1]));

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u_fast (
        .clk(clk), .rst(rst), .tx_data(data[2]), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .tx_dout(dout[2]), .tx_busy(busy[2]), .tx_done(done[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line value k cycles after the accepting edge, from the frame layout.
    function automatic logic exp_bit(input logic [7:0] w, input int k, input int idx);
        int pos;
        int ones;
        pos  = k / cpb_of[idx];
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(w[i]);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return w[pos-1];
        if (pe_of[idx] != 0 && pos == 9) return 1'(((ones + odd_of[idx]) % 2));
        return 1'b1;
    endfunction

    function automatic int frame_len(input int idx);
        return (2 + 8 + pe_of[idx]) * cpb_of[idx];
    endfunction

    // Entered just after the accepting edge; leaves just after the completing edge.
    task automatic watch_frame(input int idx, input logic [7:0] w);
        int f;
        f = frame_len(idx);
        for (int k = 0; k < f; k++) begin
            chk($sformatf("u%0d w=%0h dout k=%0d", idx, w, k), dout[idx], exp_bit(w, k, idx));
            chk($sformatf("u%0d busy k=%0d", idx, k), busy[idx], 1);
            chk($sformatf("u%0d ready k=%0d", idx, k), ready[idx], 0);
            chk($sformatf("u%0d done early k=%0d", idx, k), done[idx], 0);
            step();
        end
        chk($sformatf("u%0d done at F", idx), done[idx], 1);
        chk($sformatf("u%0d ready at F", idx), ready[idx], 1);
        chk($sformatf("u%0d busy at F", idx), busy[idx], 0);
        chk($sformatf("u%0d idle line at F", idx), dout[idx], 1);
    endtask

    task automatic wait_ready(input int idx);
        int t;
        t = 0;
        while (ready[idx] !== 1'b1 && t < 200) begin
            step();
            t++;
        end
        chk($sformatf("u%0d ready before send", idx), ready[idx], 1);
    endtask

    task automatic send(input int idx, input logic [7:0] w);
        wait_ready(idx);
        data[idx]  = w;
        valid[idx] = 1'b1;
        step();
        valid[idx] = 1'b0;
        data[idx]  = 8'(~w);
        watch_frame(idx, w);
        step();
        chk($sformatf("u%0d done one-shot", idx), done[idx], 0);
        chk($sformatf("u%0d idle line after", idx), dout[idx], 1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            valid[i] = 1'b0;
            data[i]  = 8'h00;
        end

        // Reset held three cycles, outputs checked during and after.
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) rst = 1'b0;
            step();
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d rst dout c=%0d", i, c), dout[i], 1);
                chk($sformatf("u%0d rst ready c=%0d", i, c), ready[i], 1);
                chk($sformatf("u%0d rst busy c=%0d", i, c), busy[i], 0);
                chk($sformatf("u%0d rst done c=%0d", i, c), done[i], 0);
            end
        end

        send(0, 8'hA5);

        // Back-to-back with valid held high; data changes while busy are ignored.
        data[0]  = 8'h00;
        valid[0] = 1'b1;
        step();
        data[0] = 8'hFF;
        watch_frame(0, 8'h00);
        step();
        valid[0] = 1'b0;
        data[0]  = 8'h5A;
        watch_frame(0, 8'hFF);
        step();
        chk("b2b done one-shot", done[0], 0);

        send(1, 8'h01);
        send(1, 8'h03);

        // Abort during data bit 3 of 0xA5.
        data[0]  = 8'hA5;
        valid[0] = 1'b1;
        step();
        valid[0] = 1'b0;
        for (int k = 0; k < 17; k++) begin
            chk($sformatf("abort pre dout k=%0d", k), dout[0], exp_bit(8'hA5, k, 0));
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort dout", dout[0], 1);
        chk("abort ready", ready[0], 1);
        chk("abort busy", busy[0], 0);
        chk("abort done", done[0], 0);
        for (int c = 0; c < 50; c++) begin
            step();
            chk($sformatf("abort no done c=%0d", c), done[0], 0);
        end
        send(0, 8'h3C);

        send(2, 8'h81);

        // Random words on random instances with random idle gaps.
        for (int n = 0; n < 12; n++) begin
            int idx;
            int gap;
            idx = int'($urandom_range(0, 2));
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) step();
            send(idx, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
